// File: rtl/dmem_target.sv
// dmem_target: responder end of the core's data-memory port.
// Accepts one load/store at a time over req/ready, waits WAIT_STATES cycles,
// performs the access and returns a one-cycle rvalid_o response.
// Optional feature macro: DMEM_TARGET_ERR_EN (drives err_o for out-of-range
// and misaligned accesses; otherwise err_o is tied low).
//
// state  | meaning
// S_IDLE | ready_o=1, waiting for req_i
// S_WAIT | request captured, counting down wait states
// S_RESP | access done, rvalid_o=1 for this cycle
module dmem_target #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int         AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_a_we;
    logic [31:0] w_a_addr;
    logic [31:0] w_a_wdata;
    logic [3:0]  w_a_be;
    logic [29:0] w_idx;
    logic [AW-1:0] w_mem_idx;
    logic        w_oob;
    logic        w_err;
    logic        w_wr_en;

    assign w_accept     = (r_state == S_IDLE) && req_i;
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    // With zero wait states the access happens on the acceptance edge, so the
    // live request is used; otherwise the captured copy is used.
    assign w_a_we    = (r_state == S_IDLE) ? we_i    : r_we;
    assign w_a_addr  = (r_state == S_IDLE) ? addr_i  : r_addr;
    assign w_a_wdata = (r_state == S_IDLE) ? wdata_i : r_wdata;
    assign w_a_be    = (r_state == S_IDLE) ? be_i    : r_be;

    assign w_idx     = w_a_addr[31:2];
    assign w_mem_idx = w_idx[AW-1:0];
    assign w_oob     = {2'b00, w_idx} >= 32'(DEPTH_WORDS);

`ifdef DMEM_TARGET_ERR_EN
    logic w_be_ok;
    logic w_mis;
    logic r_err;

    // Legal store byte-enable patterns: full word, aligned halfword, single byte.
    always_comb begin
        w_be_ok = 1'b0;
        case (w_a_be)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_be_ok = 1'b1;
            default:                            w_be_ok = 1'b0;
        endcase
    end

    assign w_mis = w_a_we ? !w_be_ok : (w_a_addr[1:0] != 2'b00);
    assign w_err = w_oob | w_mis;

    // Error flag is updated with the access and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_err <= 1'b0;
        else if (w_enter_resp) r_err <= w_err;
    end

    assign err_o = r_err;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^w_a_addr[1:0];
    assign w_err        = 1'b0;
    assign err_o        = 1'b0;
`endif

    assign w_wr_en = w_enter_resp && w_a_we && !w_oob && !w_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_i) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        ready_o  = (r_state == S_IDLE);
        rvalid_o = (r_state == S_RESP);
    end

    // Wait-state down-counter and request capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
        end else if (w_accept) begin
            r_cnt   <= LP_WAIT;
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_be    <= be_i;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Load data register; cleared for stores and blocked accesses, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
        end else if (w_enter_resp) begin
            if (w_a_we || w_oob || w_err) r_rdata <= 32'd0;
            else                          r_rdata <= r_mem[w_mem_idx];
        end
    end

    assign rdata_o = r_rdata;

    // Word array: byte-masked writes, no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_a_be[k]) r_mem[w_mem_idx][8*k +: 8] <= w_a_wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_target.sv
// Testbench for dmem_target: one instance with WAIT_STATES=1, one with 0.
module tb_dmem_target;
`ifdef DMEM_TARGET_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk, rst_n, req1, req0, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        rdy1, rv1, er1, rdy0, rv0, er0;
    logic [31:0] rd1, rd0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m1 [int];
    logic [31:0] m0 [int];

    dmem_target #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req1), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(rdy1), .rvalid_o(rv1),
        .rdata_o(rd1), .err_o(er1));

    dmem_target #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(rdy0), .rvalid_o(rv0),
        .rdata_o(rd0), .err_o(er0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: spec rules applied to a sparse word array per instance.
    task automatic model_access(input bit sel, input bit w, input logic [31:0] a, d,
                                input logic [3:0] b, output bit known,
                                output logic [31:0] rd, output logic e);
        int i; bit oob, mis, blk, ex; logic [31:0] m, cur;
        i   = int'(a[31:2]);
        oob = a[31:2] >= 30'd1024;
        mis = w ? !(b inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000})
                : (a[1:0] != 2'b00);
        e   = ERR_EN && (oob || mis);
        blk = oob || e;
        ex  = sel ? m1.exists(i) : m0.exists(i);
        known = 1'b1;
        rd    = 32'd0;
        if (w) begin
            if (!blk) begin
                m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
                if (ex) begin
                    cur = sel ? m1[i] : m0[i];
                    cur = (cur & ~m) | (d & m);
                    if (sel) m1[i] = cur; else m0[i] = cur;
                end else if (b == 4'hF) begin
                    if (sel) m1[i] = d; else m0[i] = d;
                end
            end
        end else if (!blk) begin
            if (ex) rd = sel ? m1[i] : m0[i];
            else    known = 1'b0;
        end
    endtask

    // Drives one request (called at a negedge) and observes 8 cycles after acceptance.
    task automatic xact(input bit sel, input bit w, input logic [31:0] a, d,
                        input logic [3:0] b, output logic [31:0] rd, output logic e,
                        output int lat, output int npulse, output int nbusy);
        int n;
        we = w; addr = a; wdata = d; be = b;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        lat = -1; npulse = 0; nbusy = 0; rd = 'x; e = 'x;
        n = 0;
        while (((sel ? rdy1 : rdy0) !== 1'b1) && n < 20) begin
            @(negedge clk); n++;
        end
        if (n >= 20) begin
            req1 = 1'b0; req0 = 1'b0;
            return;
        end
        @(negedge clk);
        req1 = 1'b0; req0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((sel ? rv1 : rv0) === 1'b1) begin
                if (npulse == 0) begin
                    lat = k; rd = sel ? rd1 : rd0; e = sel ? er1 : er0;
                end
                npulse++;
            end
            if ((sel ? rdy1 : rdy0) !== 1'b1) nbusy++;
            if (k < 7) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req1 = 1'b0; req0 = 1'b0; we = 1'b0;
        addr = 32'd0; wdata = 32'd0; be = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({rdy1, rv1, rd1, er1} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            errors++; $display("FAIL reset_dut1: got rdy=%b rv=%b rd=%h err=%b required 1 0 00000000 0", rdy1, rv1, rd1, er1);
        end
        checks++; if ({rdy0, rv0, rd0, er0} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            errors++; $display("FAIL reset_dut0: got rdy=%b rv=%b rd=%h err=%b required 1 0 00000000 0", rdy0, rv0, rd0, er0);
        end
    endtask

    task automatic test_store_latency();
        logic [31:0] rd, erd; logic e, ee; bit kn; int lat, np, nb;
        model_access(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, kn, erd, ee);
        xact(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, np, nb);
        checks++; if (lat !== 1) begin errors++; $display("FAIL store_latency: got %0d required 1", lat); end
        checks++; if (np !== 1) begin errors++; $display("FAIL store_pulses: got %0d required 1", np); end
        checks++; if (nb !== 2) begin errors++; $display("FAIL store_busy_cycles: got %0d required 2", nb); end
        checks++; if ({rd, e} !== {erd, ee}) begin errors++; $display("FAIL store_resp: got %h/%b required %h/%b", rd, e, erd, ee); end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd, erd; logic e, ee; bit kn; int lat, np, nb;
        model_access(1, 0, 32'h10, 32'h0, 4'h0, kn, erd, ee);
        xact(1, 0, 32'h10, 32'h0, 4'h0, rd, e, lat, np, nb);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word: got %h required deadbeef", rd); end
        model_access(1, 1, 32'h10, 32'hAA, 4'b0001, kn, erd, ee);
        xact(1, 1, 32'h10, 32'hAA, 4'b0001, rd, e, lat, np, nb);
        checks++; if (np !== 1) begin errors++; $display("FAIL byte_store_pulses: got %0d required 1", np); end
        model_access(1, 0, 32'h10, 32'h0, 4'h0, kn, erd, ee);
        xact(1, 0, 32'h10, 32'h0, 4'h0, rd, e, lat, np, nb);
        checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL byte_merge: got %h required deadbeaa", rd); end
        checks++; if (rd !== erd) begin errors++; $display("FAIL byte_merge_model: got %h required %h", rd, erd); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        logic [3:0]  legal [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        bit          ow [N];
        logic [31:0] oa [N], od [N];
        logic [3:0]  ob [N];
        logic [32:0] q [$];
        logic [32:0] exp;
        logic [31:0] erd; logic ee; bit kn, prev, acc;
        int idx, nresp;
        for (int i = 0; i < N; i++) begin
            ow[i] = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            oa[i] = (i < 4) ? 32'(i * 4) : 32'($urandom_range(0, 3) * 4);
            od[i] = $urandom;
            ob[i] = (i < 4) ? 4'hF : legal[$urandom_range(0, 6)];
        end
        idx = 0; nresp = 0; prev = 1'b0;
        we = ow[0]; addr = oa[0]; wdata = od[0]; be = ob[0]; req0 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            checks++; if (rv0 !== prev) begin errors++; $display("FAIL b2b_rvalid cycle %0d: got %b required %b", c, rv0, prev); end
            if (prev) begin
                exp = (q.size() > 0) ? q.pop_front() : 33'h0;
                checks++; if ({rd0, er0} !== exp) begin errors++; $display("FAIL b2b_resp %0d: got %h/%b required %h/%b", nresp, rd0, er0, exp[32:1], exp[0]); end
                nresp++;
            end
            if (req0) begin
                checks++; if (rdy0 !== !prev) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b required %b", c, rdy0, !prev); end
            end
            if (prev) begin
                idx++;
                if (idx < N) begin we = ow[idx]; addr = oa[idx]; wdata = od[idx]; be = ob[idx]; end
                else req0 = 1'b0;
            end
            acc = req0 && (rdy0 === 1'b1);
            if (acc) begin
                model_access(0, we, addr, wdata, be, kn, erd, ee);
                q.push_back({erd, ee});
            end
            prev = acc;
            @(negedge clk);
        end
        req0 = 1'b0;
        checks++; if (nresp !== N) begin errors++; $display("FAIL b2b_count: got %0d required %0d", nresp, N); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, erd; logic e, ee; bit kn; int lat, np, nb;
        model_access(1, 1, 32'h0, 32'h0BADF00D, 4'hF, kn, erd, ee);
        xact(1, 1, 32'h0, 32'h0BADF00D, 4'hF, rd, e, lat, np, nb);
        model_access(1, 0, 32'h1000, 32'h0, 4'h0, kn, erd, ee);
        xact(1, 0, 32'h1000, 32'h0, 4'h0, rd, e, lat, np, nb);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL oob_load_data: got %h required 00000000", rd); end
        checks++; if (e !== ERR_EN) begin errors++; $display("FAIL oob_load_err: got %b required %b", e, ERR_EN); end
        model_access(1, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, kn, erd, ee);
        xact(1, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, e, lat, np, nb);
        checks++; if ({np, e} !== {32'd1, ee}) begin errors++; $display("FAIL oob_store: got pulses %0d err %b required 1 %b", np, e, ee); end
        xact(1, 0, 32'h0, 32'h0, 4'h0, rd, e, lat, np, nb);
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL oob_store_alias: got %h required 0badf00d", rd); end
        xact(1, 1, 32'hFFC, 32'h5A5A1234, 4'hF, rd, e, lat, np, nb);
        model_access(1, 1, 32'hFFC, 32'h5A5A1234, 4'hF, kn, erd, ee);
        xact(1, 0, 32'hFFC, 32'h0, 4'h0, rd, e, lat, np, nb);
        checks++; if ({rd, e} !== {32'h5A5A1234, 1'b0}) begin errors++; $display("FAIL last_word: got %h/%b required 5a5a1234/0", rd, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic e, ee; bit kn; int lat, np, nb, nrv;
        model_access(1, 1, 32'h20, 32'h11111111, 4'hF, kn, erd, ee);
        xact(1, 1, 32'h20, 32'h11111111, 4'hF, rd, e, lat, np, nb);
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL mid_in_wait: got ready %b required 0", rdy1); end
        rst_n = 1'b0;
        #1;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL mid_async_reset: got ready %b required 1", rdy1); end
        nrv = 0;
        repeat (2) begin @(negedge clk); if (rv1 !== 1'b0) nrv++; end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin @(negedge clk); if (rv1 !== 1'b0) nrv++; end
        checks++; if (nrv !== 0) begin errors++; $display("FAIL mid_rvalid: got %0d pulses required 0", nrv); end
        checks++; if ({rdy1, rd1} !== {1'b1, 32'd0}) begin errors++; $display("FAIL mid_idle: got ready %b rdata %h required 1 00000000", rdy1, rd1); end
        xact(1, 0, 32'h20, 32'h0, 4'h0, rd, e, lat, np, nb);
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL mid_discard: got %h required 11111111", rd); end
    endtask

    task automatic test_align();
        logic [31:0] rd, erd; logic e, ee; bit kn; int lat, np, nb;
        model_access(1, 0, 32'h22, 32'h0, 4'h0, kn, erd, ee);
        xact(1, 0, 32'h22, 32'h0, 4'h0, rd, e, lat, np, nb);
        checks++; if ({rd, e} !== {erd, ee}) begin errors++; $display("FAIL misaligned_load: got %h/%b required %h/%b", rd, e, erd, ee); end
        checks++; if (e !== ERR_EN) begin errors++; $display("FAIL misaligned_load_err: got %b required %b", e, ERR_EN); end
        model_access(1, 1, 32'h20, 32'hFFFFFFFF, 4'b0110, kn, erd, ee);
        xact(1, 1, 32'h20, 32'hFFFFFFFF, 4'b0110, rd, e, lat, np, nb);
        checks++; if (e !== ERR_EN) begin errors++; $display("FAIL bad_be_err: got %b required %b", e, ERR_EN); end
        model_access(1, 0, 32'h20, 32'h0, 4'h0, kn, erd, ee);
        xact(1, 0, 32'h20, 32'h0, 4'h0, rd, e, lat, np, nb);
        checks++; if (rd !== erd) begin errors++; $display("FAIL bad_be_array: got %h required %h", rd, erd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, d; logic e, ee; logic [3:0] b; bit kn, w; int lat, np, nb, wi;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model_access(1, 1, 32'(i * 4), d, 4'hF, kn, erd, ee);
            xact(1, 1, 32'(i * 4), d, 4'hF, rd, e, lat, np, nb);
        end
        for (int t = 0; t < 40; t++) begin
            w  = 1'($urandom_range(0, 1));
            wi = $urandom_range(0, 17);
            if (wi >= 16) wi = 1024 + wi;
            a  = 32'(wi * 4) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            d  = $urandom;
            b  = 4'($urandom_range(0, 15));
            model_access(1, w, a, d, b, kn, erd, ee);
            xact(1, w, a, d, b, rd, e, lat, np, nb);
            checks++; if ({lat, np} !== {32'd1, 32'd1}) begin errors++; $display("FAIL rand_timing %0d: got lat %0d pulses %0d required 1 1", t, lat, np); end
            checks++; if (e !== ee) begin errors++; $display("FAIL rand_err %0d: got %b required %b", t, e, ee); end
            if (kn) begin
                checks++; if (rd !== erd) begin errors++; $display("FAIL rand_data %0d: we=%b addr=%h be=%h got %h required %h", t, w, a, b, rd, erd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_latency();
        test_byte_store();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_align();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
